// File: rtl/eep_resp_pkg.sv
// Shared types and constants for the EEPROM responder: FSM encoding, widths and the
// default charge-pump duration.
package eep_resp_pkg;

    localparam int unsigned DataW         = 14;
    localparam int unsigned AddrW         = 2;
    localparam int unsigned NumWords      = 4;
    localparam int unsigned CntW          = 8;
    localparam int unsigned DefPumpCycles = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPump  = 2'd2
    } eep_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/eep_resp.sv
// Four-word flop-based EEPROM model: registered reads, and writes that only commit after the
// charge pump has been held on for PUMP_CYCLES consecutive cycles.
module eep_resp
    import eep_resp_pkg::*;
#(
    parameter int unsigned      PUMP_CYCLES = DefPumpCycles,
    parameter logic [DataW-1:0] INIT0       = 14'h0000,
    parameter logic [DataW-1:0] INIT1       = 14'h0000,
    parameter logic [DataW-1:0] INIT2       = 14'h0000,
    parameter logic [DataW-1:0] INIT3       = 14'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             eep_cs_n,
    input  logic             eep_r_w_n,
    input  logic [AddrW-1:0] eep_addr,
    input  logic [DataW-1:0] eep_wr_data,
    input  logic             chrg_pmp_en,
    output logic [DataW-1:0] eep_rd_data,
    output logic             eep_busy,
    output logic             wr_done,
    output logic             wr_err
);

    localparam logic [CntW-1:0] PumpTarget = CntW'(PUMP_CYCLES);

    eep_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [DataW-1:0] mem_q [NumWords];
    logic [AddrW-1:0] lat_addr_q;
    logic [DataW-1:0] lat_data_q;

    logic             wr_req;
    logic             rd_req;
    logic [CntW-1:0]  cnt_inc;

    assign wr_req  = ~eep_cs_n & ~eep_r_w_n;
    assign rd_req  = ~eep_cs_n &  eep_r_w_n;
    assign cnt_inc = sat_inc(cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            eep_rd_data <= '0;
            eep_busy    <= 1'b0;
            wr_done     <= 1'b0;
            wr_err      <= 1'b0;
            lat_addr_q  <= '0;
            lat_data_q  <= '0;
            mem_q[0]    <= INIT0;
            mem_q[1]    <= INIT1;
            mem_q[2]    <= INIT2;
            mem_q[3]    <= INIT3;
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rd_req) begin
                        eep_rd_data <= mem_q[eep_addr];
                    end else if (wr_req) begin
                        lat_addr_q <= eep_addr;
                        lat_data_q <= eep_wr_data;
                        state_q    <= StArmed;
                        eep_busy   <= 1'b1;
                    end
                end
                StArmed: begin
                    // Later writes replace the pending one; it is armed until the pump starts.
                    if (wr_req) begin
                        lat_addr_q <= eep_addr;
                        lat_data_q <= eep_wr_data;
                    end
                    if (chrg_pmp_en) begin
                        state_q <= StPump;
                        cnt_q   <= CntW'(1);
                    end
                end
                StPump: begin
                    if (!chrg_pmp_en) begin
                        // Pump dropout wins over any simultaneous write: a single error pulse.
                        wr_err   <= 1'b1;
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        eep_busy <= 1'b0;
                    end else begin
                        if (wr_req) begin
                            wr_err <= 1'b1;
                        end
                        if (cnt_inc >= PumpTarget) begin
                            mem_q[lat_addr_q] <= lat_data_q;
                            wr_done           <= 1'b1;
                            state_q           <= StIdle;
                            cnt_q             <= '0;
                            eep_busy          <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    cnt_q    <= '0;
                    eep_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eep_resp.sv
// Self-checking bench for eep_resp: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a transaction-level reference model.
module tb_eep_resp;

    localparam int unsigned Pump = 16;
    localparam logic [13:0] Init [4] = '{14'h0101, 14'h0202, 14'h0303, 14'h0404};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eep_cs_n = 1'b1;
    logic        eep_r_w_n = 1'b1;
    logic [1:0]  eep_addr = '0;
    logic [13:0] eep_wr_data = '0;
    logic        chrg_pmp_en = 1'b0;
    logic [13:0] eep_rd_data;
    logic        eep_busy;
    logic        wr_done;
    logic        wr_err;

    eep_resp #(
        .PUMP_CYCLES (Pump),
        .INIT0       (14'h0101),
        .INIT1       (14'h0202),
        .INIT2       (14'h0303),
        .INIT3       (14'h0404)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .eep_cs_n    (eep_cs_n),
        .eep_r_w_n   (eep_r_w_n),
        .eep_addr    (eep_addr),
        .eep_wr_data (eep_wr_data),
        .chrg_pmp_en (chrg_pmp_en),
        .eep_rd_data (eep_rd_data),
        .eep_busy    (eep_busy),
        .wr_done     (wr_done),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: memory contents, the pending write (if any) and how long the pump has run.
    logic [13:0] m_mem [4];
    logic [13:0] m_rd;
    bit          m_pending;
    bit          m_pumping;
    int          m_pump_len;
    logic [1:0]  m_addr;
    logic [13:0] m_data;
    bit          m_done;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = Init[i];
        m_rd       = '0;
        m_pending  = 0;
        m_pumping  = 0;
        m_pump_len = 0;
        m_addr     = '0;
        m_data     = '0;
        m_done     = 0;
        m_err      = 0;
    endtask

    // One clock of the model, from the inputs presented during that cycle.
    task automatic model_step(input logic cs_n, input logic rw_n, input logic [1:0] a,
                              input logic [13:0] d, input logic pmp);
        bit wr = !cs_n && !rw_n;
        bit rd = !cs_n && rw_n;
        m_done = 0;
        m_err  = 0;
        if (m_pumping) begin
            if (!pmp) begin
                m_err      = 1;
                m_pumping  = 0;
                m_pump_len = 0;
            end else begin
                if (wr) m_err = 1;
                m_pump_len++;
                if (m_pump_len >= Pump) begin
                    m_mem[m_addr] = m_data;
                    m_done        = 1;
                    m_pumping     = 0;
                    m_pump_len    = 0;
                end
            end
        end else if (m_pending) begin
            if (wr) begin
                m_addr = a;
                m_data = d;
            end
            if (pmp) begin
                m_pending  = 0;
                m_pumping  = 1;
                m_pump_len = 1;
            end
        end else if (rd) begin
            m_rd = m_mem[a];
        end else if (wr) begin
            m_pending = 1;
            m_addr    = a;
            m_data    = d;
        end
    endtask

    task automatic step(input logic cs_n, input logic rw_n, input logic [1:0] a,
                        input logic [13:0] d, input logic pmp);
        eep_cs_n    = cs_n;
        eep_r_w_n   = rw_n;
        eep_addr    = a;
        eep_wr_data = d;
        chrg_pmp_en = pmp;
        model_step(cs_n, rw_n, a, d, pmp);
        @(posedge clk);
        #1;
        check("rd_data", 32'(eep_rd_data), 32'(m_rd));
        check("busy", 32'(eep_busy), 32'(m_pending || m_pumping));
        check("wr_done", 32'(wr_done), 32'(m_done));
        check("wr_err", 32'(wr_err), 32'(m_err));
    endtask

    task automatic idle(input logic pmp);
        step(1'b1, 1'b1, 2'd0, 14'h0, pmp);
    endtask

    task automatic do_read(input logic [1:0] a, input logic [13:0] exp, input string tag);
        step(1'b0, 1'b1, a, 14'h0, 1'b0);
        check(tag, 32'(eep_rd_data), 32'(exp));
    endtask

    task automatic do_write(input logic [1:0] a, input logic [13:0] d);
        step(1'b0, 1'b0, a, d, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        eep_cs_n    = 1'b1;
        chrg_pmp_en = 1'b0;
        model_reset();
        #1;
        check("rst_rd_data", 32'(eep_rd_data), 32'h0);
        check("rst_busy", 32'(eep_busy), 32'h0);
        check("rst_wr_done", 32'(wr_done), 32'h0);
        check("rst_wr_err", 32'(wr_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reads of factory contents.
        for (int i = 0; i < 4; i++) do_read(2'(i), Init[i], "init_read");
        check("rd_hold", 32'(eep_rd_data), 32'h0404);
        idle(1'b1);
        check("idle_pump_busy", 32'(eep_busy), 32'h0);

        // Full pump commits on its 16th cycle.
        do_write(2'd2, 14'h1ABC);
        check("armed_busy", 32'(eep_busy), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            idle(1'b1);
            check("commit_done", 32'(wr_done), 32'(i == 16));
        end
        idle(1'b0);
        check("post_commit_busy", 32'(eep_busy), 32'h0);
        do_read(2'd2, 14'h1ABC, "commit_read");

        // Pump dropout after 10 cycles aborts.
        do_write(2'd1, 14'h0555);
        for (int i = 0; i < 10; i++) idle(1'b1);
        idle(1'b0);
        check("abort_err", 32'(wr_err), 32'h1);
        idle(1'b0);
        check("abort_err_once", 32'(wr_err), 32'h0);
        do_read(2'd1, 14'h0202, "abort_read");

        // Write during pump is rejected and the original commit proceeds.
        do_write(2'd0, 14'h0AAA);
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) begin
                step(1'b0, 1'b0, 2'd3, 14'h3333, 1'b1);
                check("reject_err", 32'(wr_err), 32'h1);
            end else begin
                idle(1'b1);
            end
        end
        check("reject_done", 32'(wr_done), 32'h1);
        do_read(2'd0, 14'h0AAA, "reject_read0");
        do_read(2'd3, 14'h0404, "reject_read3");

        // Drop plus write in the same pump cycle: one error, nothing latched.
        do_write(2'd1, 14'h0777);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 2'd2, 14'h2222, 1'b0);
        check("drop_wr_err", 32'(wr_err), 32'h1);
        check("drop_wr_busy", 32'(eep_busy), 32'h0);
        do_read(2'd2, 14'h1ABC, "drop_wr_read");

        // Last write in ARMED wins.
        do_reset();
        do_write(2'd0, 14'h0011);
        do_write(2'd1, 14'h0022);
        for (int i = 0; i < 16; i++) idle(1'b1);
        do_read(2'd1, 14'h0022, "lastwin_read1");
        do_read(2'd0, 14'h0101, "lastwin_read0");

        // Reset at pump cycle 8 discards the write.
        do_write(2'd3, 14'h1234);
        for (int i = 0; i < 8; i++) idle(1'b1);
        do_reset();
        idle(1'b1);
        for (int i = 0; i < 4; i++) do_read(2'(i), Init[i], "midrst_read");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic cs_n;
            logic rw_n;
            logic pmp;
            cs_n = ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1;
            rw_n = 1'($urandom_range(0, 1));
            pmp  = ($urandom_range(0, 99) < 93) ? 1'b1 : 1'b0;
            step(cs_n, rw_n, 2'($urandom_range(0, 3)), 14'($urandom_range(0, 16383)), pmp);
        end
        for (int i = 0; i < 20; i++) idle(1'b0);
        for (int i = 0; i < 4; i++) do_read(2'(i), m_mem[i], "final_read");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
